scan_display: RTL and testbench
===============================

SCAN_DISPLAY -- requirements
Module: scan_display

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use a synchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 CNT4  in  2  scan phase from the upstream 2-bit counter; value i selects digit i.
REQ-005 LOAD  in  1  one-cycle strobe; capture DIN into the staging register.
REQ-006 DIN  in  16  four BCD digits; [3:0]=digit0 (rightmost), [15:12]=digit3.
REQ-007 BLANK_LZ  in  1  when 1, enable leading-zero blanking.
REQ-008 AN  out  4  active-low digit enables; bit i drives digit i.
REQ-009 SEG  out  7  active-low segments {g,f,e,d,c,b,a}.
REQ-010 PEND  out  1  staged data is waiting and is not yet displayed.
REQ-011 FRAME  out  1  one-cycle pulse after each display-register update.

Function
REQ-012 The block SHALL hold a 16-bit staging register and a 16-bit display register, and SHALL capture DIN into the staging register at the clock edge following any cycle with LOAD=1.
REQ-013 The block SHALL register the previous CNT4 value (prev_ph) every cycle, and SHALL define a frame boundary as a cycle where prev_ph=3 and CNT4=0.
REQ-014 In a boundary cycle, the display register SHALL load the staging register contents present at the start of that cycle, and FRAME SHALL be 1 in the following cycle only.
REQ-015 PEND SHALL set on LOAD and SHALL clear on a boundary; if LOAD and a boundary occur in the same cycle, the display register SHALL take the old staging value and PEND SHALL be 1 afterwards.
REQ-016 Any other CNT4 transition, including jumps and a held value, SHALL NOT be a boundary; a stalled CNT4 SHALL leave AN and SEG static.
REQ-017 AN and SEG SHALL be registered, with 1-cycle latency from CNT4: AN = all ones except bit CNT4 = 0, and SEG = decode of display digit CNT4.
REQ-018 The decode table (SEG, binary) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 Digit values 10-15 SHALL decode to SEG=1111111 (blank).
REQ-020 When BLANK_LZ=1, digit i (i=1..3) SHALL show SEG=1111111 if it and all higher digits are 0.
REQ-021 Digit0 SHALL never be blanked by leading-zero blanking.
REQ-022 A blanked digit SHALL still assert its AN bit low.
REQ-023 BLANK_LZ SHALL be sampled combinationally with the display register when forming the registered SEG value.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL set: staging=0, display=0, prev_ph=0, PEND=0, FRAME=0, AN=1111, SEG=1111111.
REQ-025 rst SHALL override LOAD and boundary in the same cycle.
REQ-026 After reset, the block SHALL require a full 3->0 CNT4 transition before the first display-register update.
REQ-027 Reset mid-frame SHALL discard pending data.

Verification
REQ-028 After reset, BLANK_LZ=0, no LOAD, CNT4 cycling 0,1,2,3 -> AN = 1110,1101,1011,0111, each one cycle late, and SEG=1000000 throughout.
REQ-029 LOAD with DIN=16'h1234 while CNT4=1 -> PEND=1 until the next 3->0 transition; then FRAME pulses once, PEND=0, and the following phases show 4,3,2,1 (SEG=0011001, 0110000, 0100100, 1111001).
REQ-030 BLANK_LZ=1 with DIN=16'h0050 latched -> digits 3 and 2 show SEG=1111111, digit1 shows 0010010, digit0 shows 1000000.
REQ-031 DIN=16'h000A latched -> digit0 shows SEG=1111111; DIN=16'h0000 with BLANK_LZ=1 -> only digit0 is lit, showing 1000000.
REQ-032 LOAD with DIN=16'h9999 in a boundary cycle, staging previously 16'h1111 -> 1111 is displayed, PEND=1, and 9999 is displayed after the next boundary.
REQ-033 rst=1 mid-frame with PEND=1 -> the next cycle shows AN=1111, SEG=1111111, PEND=0, FRAME=0, and 0000 is displayed after the first 3->0 transition.

Source files
------------

// File: rtl/scan_display.sv
// Four-digit multiplexed 7-segment driver with staged BCD data, frame-aligned
// display updates and optional leading-zero blanking.
module scan_display (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  CNT4,
    input  logic        LOAD,
    input  logic [15:0] DIN,
    input  logic        BLANK_LZ,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        PEND,
    output logic        FRAME
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [15:0] staging;
    logic [15:0] display;
    logic [1:0]  prev_ph;
    logic        boundary;

    logic [3:0]  cur_digit;
    logic [3:0]  zero_up;      // bit i: digit i and all higher digits are zero
    logic        lz_blank;
    logic [6:0]  seg_next;
    logic [3:0]  an_next;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign boundary = (prev_ph == 2'd3) && (CNT4 == 2'd0);

    always_comb begin
        zero_up    = '0;
        zero_up[3] = (display[15:12] == 4'd0);
        zero_up[2] = zero_up[3] && (display[11:8] == 4'd0);
        zero_up[1] = zero_up[2] && (display[7:4] == 4'd0);
        // Digit0 is never subject to leading-zero blanking.
        zero_up[0] = 1'b0;
    end

    always_comb begin
        cur_digit = display[{CNT4, 2'b00} +: 4];
        lz_blank  = BLANK_LZ && zero_up[CNT4];
        seg_next  = lz_blank ? SEG_BLANK : bcd_to_seg(cur_digit);
        an_next   = ~(4'b0001 << CNT4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            staging <= '0;
            display <= '0;
            prev_ph <= '0;
            PEND    <= 1'b0;
            FRAME   <= 1'b0;
            AN      <= '1;
            SEG     <= '1;
        end else begin
            prev_ph <= CNT4;
            FRAME   <= boundary;
            AN      <= an_next;
            SEG     <= seg_next;
            if (LOAD)
                staging <= DIN;
            // Display takes the pre-edge staging value even when LOAD coincides.
            if (boundary)
                display <= staging;
            if (LOAD)
                PEND <= 1'b1;
            else if (boundary)
                PEND <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scan_display.sv
// Directed bench for scan_display: reset, scanning, staging/frame timing,
// decode and leading-zero blanking.
module tb_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  CNT4;
    logic        LOAD;
    logic [15:0] DIN;
    logic        BLANK_LZ;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        PEND;
    logic        FRAME;

    int unsigned errors = 0;
    int unsigned checks = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    scan_display dut (
        .clk      (clk),
        .rst      (rst),
        .CNT4     (CNT4),
        .LOAD     (LOAD),
        .DIN      (DIN),
        .BLANK_LZ (BLANK_LZ),
        .AN       (AN),
        .SEG      (SEG),
        .PEND     (PEND),
        .FRAME    (FRAME)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic phase(input logic [1:0] ph);
        CNT4 = ph;
        step();
    endtask

    // Runs one scan frame 0..3 and checks each digit's registered outputs.
    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an  [4];
        exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
        exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            phase(2'(i));
            check_val($sformatf("%s an%0d", tag, i), {12'h0, AN}, {12'h0, exp_an[i]});
            check_val($sformatf("%s seg%0d", tag, i), {9'h0, SEG}, {9'h0, exp_seg[i]});
        end
    endtask

    // Loads a value in phase 1 and advances through the boundary that displays it.
    task automatic load_and_show(input logic [15:0] val);
        phase(2'd0);
        CNT4 = 2'd1; LOAD = 1'b1; DIN = val;
        step();
        LOAD = 1'b0;
        phase(2'd2);
        phase(2'd3);
        phase(2'd0);
        phase(2'd1);
        phase(2'd2);
        phase(2'd3);
    endtask

    initial begin
        rst = 1'b1; CNT4 = 2'd0; LOAD = 1'b0; DIN = '0; BLANK_LZ = 1'b0;
        step();
        check_val("rst an",    {12'h0, AN}, 16'h000F);
        check_val("rst seg",   {9'h0, SEG}, {9'h0, SB});
        check_val("rst pend",  {15'h0, PEND}, 16'h0);
        check_val("rst frame", {15'h0, FRAME}, 16'h0);
        rst = 1'b0;

        // Idle scan after reset: zeros everywhere
        check_frame("idle", S0, S0, S0, S0);

        // Load 1234 in phase 1; pending until the next 3->0
        phase(2'd0);
        CNT4 = 2'd1; LOAD = 1'b1; DIN = 16'h1234;
        step();
        LOAD = 1'b0;
        check_val("1234 pend p1", {15'h0, PEND}, 16'h1);
        phase(2'd2);
        check_val("1234 pend p2", {15'h0, PEND}, 16'h1);
        check_val("1234 seg p2 old", {9'h0, SEG}, {9'h0, S0});
        phase(2'd3);
        check_val("1234 pend p3", {15'h0, PEND}, 16'h1);
        check_val("1234 frame p3", {15'h0, FRAME}, 16'h0);
        phase(2'd0);
        check_val("1234 pend bnd", {15'h0, PEND}, 16'h0);
        check_val("1234 frame bnd", {15'h0, FRAME}, 16'h1);
        phase(2'd1);
        check_val("1234 frame off", {15'h0, FRAME}, 16'h0);
        check_val("1234 seg p1", {9'h0, SEG}, {9'h0, S3});
        phase(2'd2);
        phase(2'd3);
        check_frame("1234", S4, S3, S2, S1);

        // Stall and jumps: no boundary, outputs static
        CNT4 = 2'd1; LOAD = 1'b1; DIN = 16'h5555;
        step();
        LOAD = 1'b0;
        phase(2'd2);
        for (int i = 0; i < 3; i++) begin
            phase(2'd2);
            check_val("stall an", {12'h0, AN}, 16'h000B);
            check_val("stall seg", {9'h0, SEG}, {9'h0, S2});
        end
        phase(2'd3);
        phase(2'd1);
        check_val("jump frame", {15'h0, FRAME}, 16'h0);
        check_val("jump pend", {15'h0, PEND}, 16'h1);
        check_val("jump seg", {9'h0, SEG}, {9'h0, S3});
        phase(2'd2);
        phase(2'd3);
        phase(2'd0);
        check_val("after jump frame", {15'h0, FRAME}, 16'h1);
        phase(2'd1);
        phase(2'd2);
        phase(2'd3);
        check_frame("5555", S5, S5, S5, S5);

        // Leading-zero blanking
        BLANK_LZ = 1'b1;
        load_and_show(16'h0050);
        check_frame("0050 lz", S0, S5, SB, SB);

        BLANK_LZ = 1'b0;
        load_and_show(16'h000A);
        check_frame("000A", SB, S0, S0, S0);

        BLANK_LZ = 1'b1;
        load_and_show(16'h0000);
        check_frame("0000 lz", S0, SB, SB, SB);
        BLANK_LZ = 1'b0;

        // LOAD coinciding with a boundary: display takes the old staging value
        phase(2'd0);
        CNT4 = 2'd1; LOAD = 1'b1; DIN = 16'h1111;
        step();
        LOAD = 1'b0;
        phase(2'd2);
        phase(2'd3);
        CNT4 = 2'd0; LOAD = 1'b1; DIN = 16'h9999;
        step();
        LOAD = 1'b0;
        check_val("coinc pend", {15'h0, PEND}, 16'h1);
        check_val("coinc frame", {15'h0, FRAME}, 16'h1);
        phase(2'd1);
        check_val("coinc seg p1", {9'h0, SEG}, {9'h0, S1});
        phase(2'd2);
        check_val("coinc seg p2", {9'h0, SEG}, {9'h0, S1});
        phase(2'd3);
        check_val("coinc seg p3", {9'h0, SEG}, {9'h0, S1});
        phase(2'd0);
        check_val("coinc pend clr", {15'h0, PEND}, 16'h0);
        phase(2'd1);
        phase(2'd2);
        phase(2'd3);
        check_frame("9999", S9, S9, S9, S9);

        // Reset mid-frame discards pending data
        phase(2'd0);
        CNT4 = 2'd1; LOAD = 1'b1; DIN = 16'h5678;
        step();
        LOAD = 1'b0;
        check_val("pre-rst pend", {15'h0, PEND}, 16'h1);
        CNT4 = 2'd3; rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("mid rst an",    {12'h0, AN}, 16'h000F);
        check_val("mid rst seg",   {9'h0, SEG}, {9'h0, SB});
        check_val("mid rst pend",  {15'h0, PEND}, 16'h0);
        check_val("mid rst frame", {15'h0, FRAME}, 16'h0);
        phase(2'd0);
        check_val("post rst no bnd", {15'h0, FRAME}, 16'h0);
        phase(2'd1);
        phase(2'd2);
        phase(2'd3);
        phase(2'd0);
        check_val("post rst bnd", {15'h0, FRAME}, 16'h1);
        phase(2'd1);
        phase(2'd2);
        phase(2'd3);
        check_frame("post rst", S0, S0, S0, S0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
